sampled_history_tracker: RTL
============================

// Module: sampled_history_tracker
// PURPOSE
//   Multi-channel sampled-value history. Captures CHANNELS input buses on each sample strobe into a
//   DEPTH-deep per-channel history; provides the sampled value, a selectable past value ($past-like)
//   and per-channel rose/fell/stable/changed flags with validity qualification.
//   Feeds assertion/monitor logic downstream of the datapath under observation.
// PARAMETERS
//   WIDTH      8   bits per channel
//   CHANNELS   4   number of independent channels
//   DEPTH      4   history entries per channel; legal range 2..16
//   RESET_VAL  '0  value every history entry takes on reset/clear (WIDTH bits)
// PORTS
//   clk            in   1                 single clock, all state on rising edge
//   rst_n          in   1                 synchronous, active-low reset
//   sample_en      in   1                 capture strobe: shift all channels' history this cycle
//   clear          in   1                 synchronous flush of history and fill count
//   ch_data_i      in   CHANNELS*WIDTH    channel c at [c*WIDTH +: WIDTH]
//   past_sel       in   SELW=$clog2(DEPTH) past index k: selects entry sampled k+1 strobes ago
//   sampled_o      out  CHANNELS*WIDTH    hist[0] per channel (most recent sample)
//   past_o         out  CHANNELS*WIDTH    hist[past_sel] per channel
//   past_valid_o   out  1                 fill_cnt > past_sel
//   rose_o         out  CHANNELS          LSB 0->1 between hist[1] and hist[0]
//   fell_o         out  CHANNELS          LSB 1->0 between hist[1] and hist[0]
//   stable_o       out  CHANNELS          hist[0] == hist[1] (full width)
//   changed_o      out  CHANNELS          hist[0] != hist[1] (full width)
//   fill_cnt_o     out  $clog2(DEPTH+1)   valid history entries, saturating at DEPTH
// BEHAVIOUR
//   - Reset (rst_n=0 at edge): all hist entries = RESET_VAL, fill_cnt = 0. Hence sampled_o/past_o =
//     RESET_VAL, past_valid_o = 0, all flag outputs = 0, fill_cnt_o = 0 from the cycle after the edge.
//   - sample_en=1 at edge: hist[0] <= ch_data_i, hist[k] <= hist[k-1] for k=1..DEPTH-1, oldest dropped;
//     fill_cnt <= min(fill_cnt+1, DEPTH). sample_en=0: history and fill_cnt hold.
//   - Latency: value presented with sample_en at edge N appears on sampled_o after edge N (1 cycle).
//   - Precedence: rst_n low > clear > sample_en. clear with sample_en: clear wins, input discarded,
//     fill_cnt = 0. Reset/clear mid-fill discards everything; no partial state survives.
//   - fill_cnt saturates at DEPTH; further strobes shift history without changing count (wrap-free).
//   - Flags are pure functions of registered hist[0], hist[1], fill_cnt (no comb path from ch_data_i).
//     All four flags forced 0 while fill_cnt < 2. With fill_cnt >= 2 exactly one of stable/changed is 1;
//     rose/fell use bit 0 only; rose and fell never both 1.
//   - past_o: combinational mux on past_sel over registered history. past_sel >= DEPTH (possible when
//     DEPTH not a power of 2): past_o = RESET_VAL, past_valid_o = 0.
//   - past_valid_o = (past_sel < DEPTH) && (fill_cnt > past_sel). past_o is RESET_VAL-filled, not X,
//     when invalid (entries never written hold RESET_VAL).
//   - Channels fully independent in data; sample_en, clear, past_sel, fill_cnt shared by all channels.
//   - Elaboration error if DEPTH < 2 or DEPTH > 16.
// STRUCTURE
//   - Package sampled_pkg: typedef sample_flags_t (struct packed: rose, fell, stable, changed);
//     localparam MAX_DEPTH = 16; function sel_width(depth) returning max(1,$clog2(depth)).
//   - Sub-module sampled_history_lane: one channel's DEPTH x WIDTH shift register, past mux, and flag
//     logic; inputs shift_en, clear_en, flags_ok, past_sel; instantiated CHANNELS times via generate.
//   - Top owns fill_cnt, precedence decode, flags_ok = (fill_cnt >= 2), past_valid_o, output packing.
// TESTING
//   1. Reset then 3 idle cycles -> sampled_o=0, past_o=0, fill_cnt_o=0, all flags 0, past_valid_o=0.
//   2. Defaults; strobe ch0 = 8'h01, 8'h02, 8'h03, 8'h04, 8'h05 on consecutive cycles -> sampled_o[ch0]=05,
//      past_sel=3 gives 8'h02, fill_cnt_o=4 (saturated), past_valid_o=1.
//   3. ch1 bit0 sequence 0,1,1,0 strobed -> after 2nd strobe rose_o[1]=1; after 3rd stable_o[1]=1,
//      rose=0; after 4th fell_o[1]=1, changed_o[1]=1. Flags all 0 after 1st strobe only (fill_cnt=1).
//   4. After 2 strobes (A5, 5A): past_sel=1 -> past_valid_o=1; past_sel=2 -> past_valid_o=0, past_o=0.
//   5. clear and sample_en both 1 with ch_data_i=8'hFF -> next cycle sampled_o=0, fill_cnt_o=0, flags 0.
//   6. DEPTH=3, past_sel=3 -> past_o=RESET_VAL, past_valid_o=0; rst_n low mid-fill (fill_cnt=2) ->
//      next cycle fill_cnt_o=0 and history RESET_VAL; sample_en=0 for 5 cycles -> outputs hold.

Source files
------------

// File: rtl/sampled_pkg.sv
// Shared types and helpers for the sampled-history tracker.
package sampled_pkg;

    typedef struct packed {
        logic rose;
        logic fell;
        logic stable;
        logic changed;
    } sample_flags_t;

    localparam int MAX_DEPTH = 16;

    function automatic int sel_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/sampled_history_lane.sv
// One channel's history shift register, past-value mux and edge/stability flags.
module sampled_history_lane
    import sampled_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter int               SELW      = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                shift_en,
    input  logic                clear_en,
    input  logic                flags_ok,
    input  logic [SELW-1:0]     past_sel,
    input  logic [WIDTH-1:0]    data,
    output logic [WIDTH-1:0]    sampled,
    output logic [WIDTH-1:0]    past,
    output sample_flags_t       flags
);

    logic [WIDTH-1:0] hist [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n || clear_en) begin
            for (int i = 0; i < DEPTH; i++) hist[i] <= RESET_VAL;
        end else if (shift_en) begin
            hist[0] <= data;
            for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
        end
    end

    assign sampled = hist[0];

    // Out-of-range selects fall through to RESET_VAL rather than X.
    always_comb begin
        past = RESET_VAL;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(past_sel) == i) past = hist[i];
        end
    end

    always_comb begin
        flags = '0;
        if (flags_ok) begin
            flags.stable  = (hist[0] == hist[1]);
            flags.changed = (hist[0] != hist[1]);
            flags.rose    = !hist[1][0] &&  hist[0][0];
            flags.fell    =  hist[1][0] && !hist[0][0];
        end
    end

endmodule

// File: rtl/sampled_history_tracker.sv
// Multi-channel sampled-value history with $past-style lookup and rose/fell/stable/changed flags.
module sampled_history_tracker
    import sampled_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               CHANNELS  = 4,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              SELW      = sel_width(DEPTH),
    localparam int              CNTW      = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sample_en,
    input  logic                      clear,
    input  logic [CHANNELS*WIDTH-1:0] ch_data_i,
    input  logic [SELW-1:0]           past_sel,
    output logic [CHANNELS*WIDTH-1:0] sampled_o,
    output logic [CHANNELS*WIDTH-1:0] past_o,
    output logic                      past_valid_o,
    output logic [CHANNELS-1:0]       rose_o,
    output logic [CHANNELS-1:0]       fell_o,
    output logic [CHANNELS-1:0]       stable_o,
    output logic [CHANNELS-1:0]       changed_o,
    output logic [CNTW-1:0]           fill_cnt_o
);

    if (DEPTH < 2 || DEPTH > MAX_DEPTH) begin : g_bad_depth
        $error("sampled_history_tracker: DEPTH must be in 2..16");
    end

    logic [CNTW-1:0] fill_cnt;
    logic            shift_en;
    logic            flags_ok;

    // clear outranks sample_en: a simultaneous strobe is discarded.
    assign shift_en = sample_en && !clear;
    assign flags_ok = (fill_cnt >= CNTW'(2));

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            fill_cnt <= '0;
        end else if (sample_en && fill_cnt != CNTW'(DEPTH)) begin
            fill_cnt <= fill_cnt + CNTW'(1);
        end
    end

    assign fill_cnt_o   = fill_cnt;
    assign past_valid_o = (int'(past_sel) < DEPTH) && (int'(fill_cnt) > int'(past_sel));

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        sample_flags_t lane_flags;

        sampled_history_lane #(
            .WIDTH     (WIDTH),
            .DEPTH     (DEPTH),
            .SELW      (SELW),
            .RESET_VAL (RESET_VAL)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .shift_en (shift_en),
            .clear_en (clear),
            .flags_ok (flags_ok),
            .past_sel (past_sel),
            .data     (ch_data_i[c*WIDTH +: WIDTH]),
            .sampled  (sampled_o[c*WIDTH +: WIDTH]),
            .past     (past_o[c*WIDTH +: WIDTH]),
            .flags    (lane_flags)
        );

        assign rose_o[c]    = lane_flags.rose;
        assign fell_o[c]    = lane_flags.fell;
        assign stable_o[c]  = lane_flags.stable;
        assign changed_o[c] = lane_flags.changed;
    end

endmodule
